// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and default sizing for the fetch-group branch predictor
package bpu_pkg;

  localparam int BPU_FETCH_WIDTH = 2;
  localparam int BPU_RAS_DEPTH   = 8;
  localparam int BPU_PHT_IDX_W   = 10;
  localparam int BPU_FW_LOG2     = $clog2(BPU_FETCH_WIDTH);
  localparam int BPU_PTR_W       = $clog2(BPU_RAS_DEPTH);

  typedef enum logic [1:0] {
    BR_COND   = 2'b00,
    BR_CALL   = 2'b01,
    BR_RETURN = 2'b10,
    BR_UNCOND = 2'b11
  } br_type_e;

  typedef enum logic [1:0] {
    RAS_NONE = 2'b00,
    RAS_PUSH = 2'b01,
    RAS_POP  = 2'b10,
    RAS_RSVD = 2'b11
  } ras_op_e;

  typedef enum logic {
    ST_REFILL = 1'b0,
    ST_READY  = 1'b1
  } bpu_state_e;

  // Prediction bundle handed to fetch alongside the group PC.
  typedef struct packed {
    logic                     taken;
    logic [BPU_FW_LOG2-1:0]   slot;
    logic [29:0]              npc;
    logic [BPU_PTR_W-1:0]     ras_ptr;
    logic [BPU_PHT_IDX_W-1:0] pht_idx;
  } bpu_pred_t;

endpackage

// File: rtl/bpu_ras_ckpt.sv
// rtl/bpu_ras_ckpt.sv - circular return address stack with pointer-only checkpoint restore
module bpu_ras_ckpt
  import bpu_pkg::*;
#(
  parameter int  RAS_DEPTH = BPU_RAS_DEPTH,
  localparam int PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [29:0]      i_push_data,
  input  logic             i_pop,
  input  logic             i_restore,
  input  logic [PTR_W-1:0] i_restore_ptr,
  input  logic [1:0]       i_restore_op,
  input  logic [29:0]      i_restore_link,
  output logic [PTR_W-1:0] o_ptr,
  output logic [29:0]      o_top
);

  logic [29:0]      r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [PTR_W-1:0] w_rptr_inc;
  ras_op_e          w_op;

  assign w_op       = ras_op_e'(i_restore_op);
  assign w_ptr_inc  = r_ptr + PTR_W'(1);
  assign w_rptr_inc = i_restore_ptr + PTR_W'(1);
  assign o_ptr      = r_ptr;
  assign o_top      = r_mem[r_ptr];

  // Pointer: a restore replaces the pointer and applies the backend op; otherwise predicted push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_restore) begin
      case (w_op)
        RAS_PUSH: r_ptr <= w_rptr_inc;
        RAS_POP:  r_ptr <= i_restore_ptr - PTR_W'(1);
        default:  r_ptr <= i_restore_ptr;
      endcase
    end else if (i_push) begin
      r_ptr <= w_ptr_inc;
    end else if (i_pop) begin
      r_ptr <= r_ptr - PTR_W'(1);
    end
  end

  // Entries: pushes write one above the pointer, wrapping over the oldest entry when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_restore) begin
      if (w_op == RAS_PUSH) r_mem[w_rptr_inc] <= i_restore_link;
    end else if (i_push) begin
      r_mem[w_ptr_inc] <= i_push_data;
    end
  end

endmodule

// File: rtl/bpu_fgroup.sv
// rtl/bpu_fgroup.sv - fetch-group next-PC generator with BTB/PHT lookup and checkpointed RAS
module bpu_fgroup
  import bpu_pkg::*;
#(
  parameter int          FETCH_WIDTH   = BPU_FETCH_WIDTH,
  parameter int          RAS_DEPTH     = BPU_RAS_DEPTH,
  parameter int          PHT_IDX_W     = BPU_PHT_IDX_W,
  parameter int          REFILL_CYCLES = 1,
  parameter logic [31:0] RESET_PC      = 32'h1c00_0000,
  localparam int         FW_LOG2       = $clog2(FETCH_WIDTH),
  localparam int         PTR_W         = $clog2(RAS_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   fetch_valid_o,
  input  logic                   fetch_ready_i,
  output logic [31:0]            pc_o,
  output logic [FETCH_WIDTH-1:0] pc_valid_o,
  output logic                   pred_taken_o,
  output logic [FW_LOG2-1:0]     pred_slot_o,
  output logic [29:0]            pred_npc_o,
  output logic [PTR_W-1:0]       pred_ras_ptr_o,
  output logic [PHT_IDX_W-1:0]   pred_pht_idx_o,
  output logic [29:0]            lookup_pc_o,
  input  logic                   btb_hit_i,
  input  logic [FW_LOG2-1:0]     btb_slot_i,
  input  logic [1:0]             btb_type_i,
  input  logic [29:0]            btb_bta_i,
  input  logic [1:0]             pht_cnt_i,
  input  logic                   redirect_i,
  input  logic [29:0]            redirect_pc_i,
  input  logic [PTR_W-1:0]       redirect_ras_ptr_i,
  input  logic [1:0]             redirect_ras_op_i,
  input  logic [29:0]            redirect_link_i
);

  localparam int CNT_W = $clog2(REFILL_CYCLES + 1);

  bpu_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [31:0]            r_pc;
  logic                   w_valid, w_fire;
  logic                   w_br_ok, w_taken, w_is_ret, w_is_call;
  logic                   w_ras_push, w_ras_pop;
  logic [FW_LOG2-1:0]     w_off;
  logic [29:0]            w_pc_w, w_base, w_seq, w_ppc, w_push_data, w_ras_top;
  logic [31:0]            w_npc;
  logic [PTR_W-1:0]       w_ras_ptr;
  logic [FETCH_WIDTH-1:0] w_slot_mask;
  logic                   w_unused;
  bpu_pred_t              w_pred;

  // Only the direction bit of the 2-bit counter matters for prediction.
  assign w_unused = pht_cnt_i[0];

  assign w_valid     = (r_state == ST_READY);
  assign w_fire      = w_valid & fetch_ready_i;
  assign w_pc_w      = r_pc[31:2];
  assign w_off       = r_pc[FW_LOG2+1:2];
  assign w_base      = {w_pc_w[29:FW_LOG2], {FW_LOG2{1'b0}}};
  assign w_seq       = w_base + 30'(FETCH_WIDTH);
  // A BTB hit on a slot before the entry offset belongs to instructions we skipped.
  assign w_br_ok     = btb_hit_i & (btb_slot_i >= w_off);
  assign w_taken     = w_br_ok & ((btb_type_i != BR_COND) | pht_cnt_i[1]);
  assign w_is_ret    = w_br_ok & (btb_type_i == BR_RETURN);
  assign w_is_call   = w_taken & (btb_type_i == BR_CALL);
  assign w_ppc       = w_is_ret ? w_ras_top : (w_taken ? btb_bta_i : w_seq);
  assign w_push_data = w_base + 30'(btb_slot_i) + 30'd1;

  // A redirect flushes the group, so it suppresses the predicted RAS op even if the group fires.
  assign w_ras_push  = w_fire & ~redirect_i & w_is_call;
  assign w_ras_pop   = w_fire & ~redirect_i & w_is_ret;

  // Next PC: redirect beats fire; an unaccepted group holds and re-reads its own table entries.
  assign w_npc       = redirect_i ? {redirect_pc_i, 2'b00} : (w_fire ? {w_ppc, 2'b00} : r_pc);
  assign lookup_pc_o = w_npc[31:2];
  assign pc_o        = r_pc;

  // Slot mask: from the entry offset up to and including a taken branch.
  always_comb begin
    w_slot_mask = '0;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      w_slot_mask[s] = w_valid & (FW_LOG2'(s) >= w_off) &
                       (~w_taken | (FW_LOG2'(s) <= btb_slot_i));
    end
  end

  // Prediction bundle, forced to zero while no group is presented.
  always_comb begin
    w_pred = '0;
    if (w_valid) begin
      w_pred.taken   = w_taken;
      w_pred.slot    = w_br_ok ? btb_slot_i : '0;
      w_pred.npc     = w_ppc;
      w_pred.ras_ptr = w_ras_ptr;
      w_pred.pht_idx = r_pc[PHT_IDX_W+FW_LOG2+1:FW_LOG2+2];
    end
  end

  assign fetch_valid_o  = w_valid;
  assign pc_valid_o     = w_slot_mask;
  assign pred_taken_o   = w_pred.taken;
  assign pred_slot_o    = w_pred.slot;
  assign pred_npc_o     = w_pred.npc;
  assign pred_ras_ptr_o = w_pred.ras_ptr;
  assign pred_pht_idx_o = w_pred.pht_idx;

  // State FSM: refill bubble after reset or redirect, then present groups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REFILL;
      r_cnt   <= CNT_W'(REFILL_CYCLES);
    end else if (redirect_i) begin
      r_state <= ST_REFILL;
      r_cnt   <= CNT_W'(REFILL_CYCLES);
    end else if (r_state == ST_REFILL) begin
      if (r_cnt <= CNT_W'(1)) r_state <= ST_READY;
      else                    r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  // Group PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC;
    else        r_pc <= w_npc;
  end

  bpu_ras_ckpt #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_push         (w_ras_push),
    .i_push_data    (w_push_data),
    .i_pop          (w_ras_pop),
    .i_restore      (redirect_i),
    .i_restore_ptr  (redirect_ras_ptr_i),
    .i_restore_op   (redirect_ras_op_i),
    .i_restore_link (redirect_link_i),
    .o_ptr          (w_ras_ptr),
    .o_top          (w_ras_top)
  );

endmodule
